// File: rtl/counter_pkg.sv
// counter_pkg: shared mode encoding and default sizes for the counter family
package counter_pkg;
  typedef enum logic [1:0] {MODE_WRAP, MODE_SAT, MODE_ONESHOT, MODE_RSVD} count_mode_t;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_PRESCALE_W = 4;
endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler: emits one tick every prescale+1 enabled cycles
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] cnt;
  // >= lets a lowered divisor fire at once instead of running the counter around
  assign tick = enable && cnt >= prescale;
  // divider state; holds while disabled, restarts on reset or load
  always_ff @(posedge clk)
    if (!reset || clear) cnt <= '0;
    else if (enable) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/updown_counter_prog.sv
// updown_counter_prog: prescaled up/down counter with wrap, saturate and one-shot end modes
module updown_counter_prog
  import counter_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PRESCALE_W = DEF_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic [1:0]            mode,
  input  logic [WIDTH-1:0]      limit,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  output logic [WIDTH-1:0]      count,
  output logic                  pulse,
  output logic                  done
);
  logic             tick, at_end, pulse_n, done_n;
  logic [WIDTH-1:0] step, count_n;
  count_mode_t      m;
  assign m = count_mode_t'(mode);
  counter_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clk(clk), .reset(reset), .enable(enable), .clear(load), .prescale(prescale), .tick(tick)
  );
  // next count/flags; load beats a tick, a finished one-shot ignores ticks
  always_comb begin
    step    = up_down ? count + 1'b1 : count - 1'b1;
    at_end  = up_down ? count >= limit : count == '0;
    count_n = count;
    pulse_n = 1'b0;
    done_n  = done;
    if (load) begin
      count_n = load_value;
      done_n  = 1'b0;
    end else if (tick && !(m == MODE_ONESHOT && done)) begin
      if (!at_end) begin
        count_n = step;
        done_n  = m == MODE_SAT ? 1'b0 : done;
      end else if (m == MODE_SAT) begin
        pulse_n = !done;
        done_n  = 1'b1;
      end else if (m == MODE_ONESHOT) begin
        pulse_n = 1'b1;
        done_n  = 1'b1;
      end else begin
        count_n = up_down ? '0 : limit;
        pulse_n = 1'b1;
      end
    end
  end
  // output registers
  always_ff @(posedge clk)
    if (!reset) begin
      count <= '0;
      pulse <= 1'b0;
      done  <= 1'b0;
    end else begin
      count <= count_n;
      pulse <= pulse_n;
      done  <= done_n;
    end
endmodule

// File: tb/tb_updown_counter_prog.sv
// tb_updown_counter_prog: directed vectors checked against a behavioural model and literals
module tb_updown_counter_prog;
  logic       clk = 0, reset = 0, enable = 0, up_down = 1, load = 0;
  logic [1:0] mode = 0;
  logic [3:0] limit = 9, prescale = 0, load_value = 0;
  logic [3:0] count;
  logic       pulse, done;
  int checks = 0, failures = 0;
  int m_count = 0, m_pre = 0;
  bit m_pulse = 0, m_done = 0, chk_on = 0;

  updown_counter_prog #(.WIDTH(4), .PRESCALE_W(4)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down), .mode(mode),
    .limit(limit), .prescale(prescale), .load(load), .load_value(load_value),
    .count(count), .pulse(pulse), .done(done)
  );

  always #5 clk = ~clk;

  // behavioural model: one tick every prescale+1 enabled cycles, then apply end-of-count rules
  always @(posedge clk) begin
    if (!reset) begin
      m_count = 0; m_pulse = 0; m_done = 0; m_pre = 0;
    end else if (load) begin
      m_count = int'(load_value); m_pulse = 0; m_done = 0; m_pre = 0;
    end else begin
      m_pulse = 0;
      if (enable) begin
        if (m_pre >= int'(prescale)) begin
          m_pre = 0;
          if (!(mode == 2 && m_done)) begin
            if (up_down ? m_count < int'(limit) : m_count != 0) begin
              m_count = (m_count + (up_down ? 1 : 15)) % 16;
              if (mode == 1) m_done = 0;
            end else if (mode == 1) begin
              m_pulse = !m_done; m_done = 1;
            end else if (mode == 2) begin
              m_pulse = 1; m_done = 1;
            end else begin
              m_count = up_down ? 0 : int'(limit); m_pulse = 1;
            end
          end
        end else m_pre++;
      end
    end
  end

  // per-cycle comparison against the model
  always @(negedge clk)
    if (chk_on) begin
      checks++;
      if ({count, pulse, done} !== {m_count[3:0], m_pulse, m_done}) begin
        failures++;
        $display("FAIL model t=%0t count=%0d/%0d pulse=%0b/%0b done=%0b/%0b (dut/model)",
                 $time, count, m_count, pulse, m_pulse, done, m_done);
      end
    end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1; load_value = v;
    cyc(1);
    load = 0;
  endtask

  initial begin
    cyc(2);
    chk_on = 1;
    chk("rst_count", count, 0); chk("rst_pulse", pulse, 0); chk("rst_done", done, 0);
    reset = 1; enable = 1;
    cyc(1); chk("wrap_first", count, 1);
    cyc(8); chk("wrap_nine", count, 9); chk("wrap_nine_p", pulse, 0);
    cyc(1); chk("wrap_zero", count, 0); chk("wrap_pulse", pulse, 1);
    cyc(1); chk("wrap_one", count, 1); chk("wrap_pulse_end", pulse, 0);
    limit = 5; prescale = 2; up_down = 0;
    do_load(2); chk("dn_load", count, 2);
    cyc(2); chk("dn_hold", count, 2);
    cyc(1); chk("dn_1", count, 1);
    cyc(3); chk("dn_0", count, 0);
    cyc(3); chk("dn_reload", count, 5); chk("dn_pulse", pulse, 1);
    cyc(1); chk("dn_pulse_end", pulse, 0);
    cyc(2); chk("dn_4", count, 4);
    limit = 15; mode = 1; up_down = 1; prescale = 0;
    do_load(13); chk("sat_load", count, 13);
    cyc(2); chk("sat_15", count, 15); chk("sat_15_p", pulse, 0);
    cyc(1); chk("sat_hold", count, 15); chk("sat_pulse", pulse, 1); chk("sat_done", done, 1);
    cyc(1); chk("sat_pulse2", pulse, 0); chk("sat_done2", done, 1);
    up_down = 0;
    cyc(1); chk("sat_rev", count, 14); chk("sat_rev_done", done, 0);
    mode = 2;
    do_load(3); chk("os_load", count, 3);
    cyc(3); chk("os_0", count, 0);
    cyc(1); chk("os_pulse", pulse, 1); chk("os_done", done, 1);
    up_down = 1;
    cyc(2); chk("os_ignore", count, 0); chk("os_done_stay", done, 1);
    do_load(7); chk("os_reload", count, 7); chk("os_reload_done", done, 0);
    cyc(1); chk("os_resume", count, 8);
    mode = 0; limit = 15;
    do_load(12);
    limit = 8;
    cyc(1); chk("lim_wrap", count, 0); chk("lim_pulse", pulse, 1);
    do_load(5); chk("load_wins", count, 5);
    enable = 0;
    cyc(3); chk("freeze", count, 5);
    prescale = 3; enable = 1;
    cyc(2); chk("pre_mid", count, 5);
    prescale = 1;
    cyc(1); chk("pre_lowered", count, 6);
    limit = 0; prescale = 0;
    do_load(0);
    cyc(1); chk("lim0_count", count, 0); chk("lim0_pulse", pulse, 1);
    cyc(1); chk("lim0_pulse2", pulse, 1);
    mode = 1; limit = 6;
    do_load(5);
    cyc(2); chk("pre_rst_done", done, 1); chk("pre_rst_count", count, 6);
    prescale = 3;
    cyc(2);
    reset = 0;
    cyc(1); chk("mrst_count", count, 0); chk("mrst_pulse", pulse, 0); chk("mrst_done", done, 0);
    reset = 1; mode = 0; limit = 9;
    cyc(3); chk("mrst_wait", count, 0);
    cyc(1); chk("mrst_tick", count, 1);
    cyc(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
